// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI front end.
// Optional build macro used by the top: AES_BUSY_TIMEOUT_EN (busy watchdog).
package aes_spi_pkg;

    // Native AES block width; key, plaintext and cyphertext share it.
    localparam int AES_BLK_W = 128;

    // Front-end sequencing states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_LOAD,
        S_BUSY,
        S_TX
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the asynchronous SPI pins into the clk domain and derives
// the sck edge strobes and chip-select edges used by the front-end FSM.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_sdi,
    input  logic spi_cs_n,
    output logic sdi,
    output logic cs,
    output logic cs_rise,
    output logic cs_fall,
    output logic sck_rise,
    output logic sck_fall
);

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_n_sync_reg;
    logic                   sck_q_reg;
    logic                   cs_q_reg;
    logic                   sck_s;
    logic                   cs_s;

    // Synchronizer chains; cs_n idles high so a reset never looks like a select.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_reg  <= '0;
            sdi_sync_reg  <= '0;
            cs_n_sync_reg <= '1;
            sck_q_reg     <= 1'b0;
            cs_q_reg      <= 1'b0;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
            sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], spi_sdi};
            cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
            sck_q_reg     <= sck_s;
            cs_q_reg      <= cs_s;
        end
    end

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s     = ~cs_n_sync_reg[SYNC_STAGES-1];
    assign sdi      = sdi_sync_reg[SYNC_STAGES-1];
    assign cs       = cs_s;
    assign cs_rise  = cs_s & ~cs_q_reg;
    assign cs_fall  = ~cs_s & cs_q_reg;
    assign sck_rise = sck_s & ~sck_q_reg;
    assign sck_fall = ~sck_s & sck_q_reg;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave front end for the multi-cycle AES core: receives a key+plaintext
// frame, starts the round controller, captures the cyphertext and serves it
// back over SPI.
// Build macro: AES_BUSY_TIMEOUT_EN adds a watchdog on the S_BUSY wait.
module aes_spi_frontend
    import aes_spi_pkg::*;
#(
    parameter int BLK_W       = AES_BLK_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sck,
    input  logic             spi_sdi,
    input  logic             spi_cs_n,
    output logic             spi_sdo,
    output logic [BLK_W-1:0] key,
    output logic [BLK_W-1:0] plaintext,
    output logic             load,
    input  logic             aes_done,
    input  logic [BLK_W-1:0] cyphertext,
    output logic             ready,
    output logic             frame_err
);

    localparam int FRAME_W = 2 * BLK_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_BLK   = CNT_W'(BLK_W);

    logic sdi, cs, cs_rise, cs_fall, sck_rise, sck_fall;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_sdi  (spi_sdi),
        .spi_cs_n (spi_cs_n),
        .sdi      (sdi),
        .cs       (cs),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    state_t             state_reg;
    logic [FRAME_W-1:0] rx_sr_reg;
    logic [BLK_W-1:0]   tx_sr_reg;
    logic [BLK_W-1:0]   ct_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   cnt_rx_next;
    logic               done_q_reg;
    logic               load_reg;
    logic               ready_reg;
    logic               frame_err_reg;

`ifdef AES_BUSY_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_reg;
`endif

    // Saturating bit count so an over-long frame can never alias to a valid one.
    always_comb begin
        cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        cnt_rx_next = sck_rise ? cnt_inc : cnt_reg;
    end

    // Front-end FSM with shift registers, bit counter and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            rx_sr_reg     <= '0;
            tx_sr_reg     <= '0;
            ct_reg        <= '0;
            cnt_reg       <= '0;
            done_q_reg    <= 1'b0;
            load_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef AES_BUSY_TIMEOUT_EN
            wd_reg        <= '0;
`endif
        end else begin
            load_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            // Tracking the done level (rather than zeroing it) means a done
            // still high from the previous operation never reads as a rise.
            done_q_reg    <= aes_done;

            case (state_reg)
                S_IDLE: begin
                    ready_reg <= 1'b0;
                    if (cs) begin
                        cnt_reg   <= '0;
                        state_reg <= S_RX;
                    end
                end

                S_RX: begin
                    // An edge coinciding with deselect is still part of the frame.
                    if (sck_rise) begin
                        rx_sr_reg <= {rx_sr_reg[FRAME_W-2:0], sdi};
                    end
                    cnt_reg <= cnt_rx_next;
                    if (!cs) begin
                        if (cnt_rx_next == CNT_FRAME) begin
                            state_reg <= S_LOAD;
                        end else begin
                            state_reg     <= S_IDLE;
                            frame_err_reg <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    load_reg  <= 1'b1;
                    state_reg <= S_BUSY;
`ifdef AES_BUSY_TIMEOUT_EN
                    wd_reg    <= '0;
`endif
                end

                S_BUSY: begin
                    if (aes_done && !done_q_reg) begin
                        tx_sr_reg <= cyphertext;
                        ct_reg    <= cyphertext;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        state_reg <= S_TX;
                    end
`ifdef AES_BUSY_TIMEOUT_EN
                    else if (wd_reg == WD_W'(TIMEOUT_CYC - 1)) begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
`endif
                end

                S_TX: begin
                    // Each new select restarts the read from the saved result.
                    if (cs_rise) begin
                        cnt_reg   <= '0;
                        tx_sr_reg <= ct_reg;
                    end else if (cs && sck_fall) begin
                        tx_sr_reg <= {tx_sr_reg[BLK_W-2:0], 1'b0};
                        cnt_reg   <= cnt_inc;
                    end
                    if (cs_fall && (cnt_reg >= CNT_BLK)) begin
                        ready_reg <= 1'b0;
                        tx_sr_reg <= '0;
                        state_reg <= S_IDLE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign key       = rx_sr_reg[FRAME_W-1:BLK_W];
    assign plaintext = rx_sr_reg[BLK_W-1:0];
    assign load      = load_reg;
    assign ready     = ready_reg;
    assign frame_err = frame_err_reg;
    assign spi_sdo   = (state_reg == S_TX) ? tx_sr_reg[BLK_W-1] : 1'b0;

endmodule
